// File: rtl/counter_defs.sv
// Shared constants for the up/down counter: direction encodings and
// parameter legality limits used by the elaboration-time check.
package counter_defs;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int WIDTH_MIN   = 2;
  localparam int WIDTH_MAX   = 16;
  localparam int MODULUS_MIN = 2;

  function automatic bit params_legal(input int w, input int m);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) &&
           (m >= MODULUS_MIN) && (m <= (1 << w));
  endfunction

endpackage

// File: rtl/t_flipflop.sv
// Single toggle flop with asynchronous active-high clear; one instance per
// counter bit.
module t_flipflop (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_t,
  output logic o_q,
  output logic o_qbar
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)    r_q <= 1'b0;
    else if (i_t) r_q <= ~r_q;
  end

  assign o_q    = r_q;
  assign o_qbar = ~r_q;

endmodule

// File: rtl/synch_updown_counter_t.sv
// Modulo-N synchronous up/down counter with clamped parallel load, a
// combinational terminal count for cascading and a registered wrap pulse.
module synch_updown_counter_t
  import counter_defs::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_param_check
    $error("synch_updown_counter_t: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_is_zero;
  logic             w_is_max;
  logic             w_wrap_evt;
  logic             r_wrap;

  assign w_is_zero = &w_qbar;
  assign w_is_max  = (w_q == MAX_VAL);

  // tc doubles as the wrap event: both mean "an enabled count edge will roll over"
  assign tc = en & ~load & (((up_dn == DIR_UP)   & w_is_max) |
                            ((up_dn == DIR_DOWN) & w_is_zero));
  assign w_wrap_evt = tc;

  always_comb begin
    w_next = w_q;
    if (load) begin
      if (32'(load_val) >= 32'(MODULUS)) w_next = MAX_VAL;
      else                               w_next = load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) w_next = w_is_max  ? '0      : w_q + 1'b1;
      else                 w_next = w_is_zero ? MAX_VAL : w_q - 1'b1;
    end
  end

  assign w_t = w_q ^ w_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_flipflop u_tff (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_t    (w_t[i]),
      .o_q    (w_q[i]),
      .o_qbar (w_qbar[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wrap <= 1'b0;
    else     r_wrap <= w_wrap_evt;
  end

  assign count = w_q;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_synch_updown_counter_t.sv
// Scoreboard bench: stimulus pushes expected {count,tc,wrap} per cycle, a
// negedge monitor pops and compares against the selected counter.
module tb_synch_updown_counter_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // mod-16 counter
  logic       en16 = 0, up16 = 1;
  logic [3:0] cnt16;
  logic       tc16, wr16;
  // mod-10 counter
  logic       en10 = 0, up10 = 1, ld10 = 0;
  logic [3:0] lv10 = '0;
  logic [3:0] cnt10;
  logic       tc10, wr10;
  // cascaded mod-10 pair
  logic       enc = 0;
  logic [3:0] cnt_lo, cnt_hi;
  logic       tc_lo, tc_hi, wr_lo, wr_hi;
  logic [3:0] zero4 = '0;
  logic       zero1 = 1'b0;
  logic       one1  = 1'b1;

  synch_updown_counter_t #(.WIDTH(4), .MODULUS(16)) u_c16 (
    .clk(clk), .rst(rst), .en(en16), .up_dn(up16), .load(zero1), .load_val(zero4),
    .count(cnt16), .tc(tc16), .wrap(wr16));

  synch_updown_counter_t #(.WIDTH(4), .MODULUS(10)) u_c10 (
    .clk(clk), .rst(rst), .en(en10), .up_dn(up10), .load(ld10), .load_val(lv10),
    .count(cnt10), .tc(tc10), .wrap(wr10));

  synch_updown_counter_t #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst(rst), .en(enc), .up_dn(one1), .load(zero1), .load_val(zero4),
    .count(cnt_lo), .tc(tc_lo), .wrap(wr_lo));

  synch_updown_counter_t #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up_dn(one1), .load(zero1), .load_val(zero4),
    .count(cnt_hi), .tc(tc_hi), .wrap(wr_hi));

  typedef struct {
    int    sel;   // 0 = mod16, 1 = mod10, 2 = cascade
    int    cnt;
    bit    tc;
    bit    wr;
    string nm;
    int    idx;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      int   ac;
      bit   at, aw;
      e = q.pop_front();
      case (e.sel)
        0:       begin ac = int'(cnt16); at = tc16; aw = wr16; end
        1:       begin ac = int'(cnt10); at = tc10; aw = wr10; end
        default: begin ac = int'(cnt_hi) * 10 + int'(cnt_lo); at = tc_hi; aw = wr_hi; end
      endcase
      n_tests++;
      if (ac != e.cnt || at != e.tc || aw != e.wr) begin
        n_fail++;
        $display("FAIL %s[%0d]: got count=%0d tc=%0b wrap=%0b, expected count=%0d tc=%0b wrap=%0b",
                 e.nm, e.idx, ac, at, aw, e.cnt, e.tc, e.wr);
      end
    end
  end

  // Push the expectation for the current cycle, then advance one edge.
  task automatic cyc(input int sel, input int ec, input bit etc, input bit ew,
                     input string nm, input int idx);
    exp_t e;
    e.sel = sel; e.cnt = ec; e.tc = etc; e.wr = ew; e.nm = nm; e.idx = idx;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;

    // reset holds zero; tc still follows inputs with count=0
    en16 = 1; up16 = 0;
    cyc(0, 0, 1, 0, "rst_hold_tc", 0);
    cyc(0, 0, 1, 0, "rst_hold_tc", 1);

    // mod-16 up run from reset
    rst = 0; up16 = 1;
    for (int k = 0; k <= 16; k++)
      cyc(0, k % 16, (k % 16) == 15, k == 16, "up16", k);
    en16 = 0;

    // load clamp: 13 -> 9, no wrap
    en10 = 1; up10 = 1; ld10 = 1; lv10 = 4'd13;
    cyc(1, 0, 0, 0, "ld13", 0);
    ld10 = 0; en10 = 0;
    cyc(1, 9, 0, 0, "ld13", 1);

    // down from 2 across zero
    ld10 = 1; lv10 = 4'd2; en10 = 1; up10 = 0;
    cyc(1, 9, 0, 0, "dn10", 0);
    ld10 = 0;
    cyc(1, 2, 0, 0, "dn10", 1);
    cyc(1, 1, 0, 0, "dn10", 2);
    cyc(1, 0, 1, 0, "dn10", 3);
    cyc(1, 9, 0, 1, "dn10", 4);
    en10 = 0;
    cyc(1, 8, 0, 0, "dn10", 5);

    // clamp boundary at load_val == MODULUS, then up-wrap 9 -> 0
    ld10 = 1; lv10 = 4'd10;
    cyc(1, 8, 0, 0, "ld10", 0);
    ld10 = 0; en10 = 1; up10 = 1;
    cyc(1, 9, 1, 0, "up10wrap", 0);
    en10 = 0;
    cyc(1, 0, 0, 1, "up10wrap", 1);

    // hold at 5 while direction toggles
    ld10 = 1; lv10 = 4'd5;
    cyc(1, 0, 0, 0, "hold5", 0);
    ld10 = 0;
    for (int k = 1; k <= 3; k++) begin
      up10 = k[0];
      cyc(1, 5, 0, 0, "hold5", k);
    end

    // async reset between edges at count 7
    ld10 = 1; lv10 = 4'd7;
    cyc(1, 5, 0, 0, "rst7", 0);
    ld10 = 0;
    cyc(1, 7, 0, 0, "rst7", 1);
    rst = 1; en10 = 1; up10 = 1;
    cyc(1, 0, 0, 0, "rst7", 2);
    rst = 0;
    cyc(1, 0, 0, 0, "rst7", 3);
    en10 = 0;
    cyc(1, 1, 0, 0, "rst7", 4);

    // cascaded pair 00..99 then 00
    enc = 1;
    for (int k = 0; k <= 100; k++)
      cyc(2, k % 100, (k % 100) == 99, k == 100, "cascade", k);
    enc = 0;

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
